// File: rtl/rotate_pkg.sv
// Shared constants and the bit-level rotate reference used by the checker.
package rotate_pkg;

    localparam int ROT_WIDTH_DEF = 8;
    localparam int ROT_AMT_W_DEF = 3;
    localparam int ROT_MAX_W     = 64;

    // Rotate the low 'width' bits of data left by amt (reduced mod width).
    function automatic logic [ROT_MAX_W-1:0] rot_l(input logic [ROT_MAX_W-1:0] data,
                                                   input int unsigned amt,
                                                   input int unsigned width);
        logic [ROT_MAX_W-1:0] res;
        res = {ROT_MAX_W{1'b0}};
        for (int unsigned i = 0; i < width; i++) begin
            res[(i + amt) % width] = data[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/rotate_left_stages.sv
// Combinational log-depth left rotator: amount reduced mod WIDTH, then one
// fixed-rotate mux stage per amount bit.
module rotate_left_stages
    import rotate_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH_DEF,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] y
);

    logic [AMT_W-1:0] amt_red_s;
    logic [WIDTH-1:0] stage_s [0:AMT_W];

    assign amt_red_s  = AMT_W'(32'(amt) % 32'(WIDTH));
    assign stage_s[0] = a;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        // Stage shift taken mod WIDTH so a zero shift degenerates to a wire.
        localparam int SH = (2 ** k) % WIDTH;
        logic [WIDTH-1:0] rot_s;
        assign rot_s          = (stage_s[k] << SH) | (stage_s[k] >> (WIDTH - SH));
        assign stage_s[k + 1] = amt_red_s[k] ? rot_s : stage_s[k];
    end

    assign y = stage_s[AMT_W];

endmodule

// File: rtl/rotate_left_unit_chk.sv
// Assertion checker for rotate_left_unit; follows ROTATE_LEFT_BIDIR_EN like the DUT.
module rotate_left_unit_chk
    import rotate_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH_DEF,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input logic             clk,
    input logic             rst_n,
    input logic             in_valid,
    input logic [WIDTH-1:0] a,
    input logic [AMT_W-1:0] amt,
`ifdef ROTATE_LEFT_BIDIR_EN
    input logic             dir,
`endif
    input logic [WIDTH-1:0] y,
    input logic             out_valid
);

    int unsigned amt_ref_s;

    // Left-rotate amount the reference function should apply this cycle.
    always_comb begin
        amt_ref_s = int'(32'(amt) % 32'(WIDTH));
`ifdef ROTATE_LEFT_BIDIR_EN
        if (dir) begin
            amt_ref_s = (WIDTH - amt_ref_s) % WIDTH;
        end else begin
            amt_ref_s = amt_ref_s;
        end
`endif
    end

    a_result: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid |=> (out_valid &&
            (y == WIDTH'(rot_l(ROT_MAX_W'($past(a)), $past(amt_ref_s), WIDTH)))));

    a_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !in_valid |=> (!out_valid && (y == $past(y))));

endmodule

// File: rtl/rotate_left_unit.sv
// Registered barrel rotator. Define ROTATE_LEFT_BIDIR_EN to add the dir port
// (dir=1 rotates right, realised as a left rotate by WIDTH - amt).
module rotate_left_unit
    import rotate_pkg::*;
#(
    parameter int WIDTH = ROT_WIDTH_DEF,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
`ifdef ROTATE_LEFT_BIDIR_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] y,
    output logic             out_valid
);

    logic [31:0]      amt_mod_s;
    logic [31:0]      amt_left_s;
    logic [AMT_W-1:0] amt_eff_s;
    logic [WIDTH-1:0] rot_s;
    logic [WIDTH-1:0] y_d,         y_q;
    logic             out_valid_d, out_valid_q;

    // Fold direction into an equivalent left-rotate amount.
    always_comb begin
        amt_mod_s  = 32'(amt) % 32'(WIDTH);
        amt_left_s = amt_mod_s;
`ifdef ROTATE_LEFT_BIDIR_EN
        if (dir) begin
            amt_left_s = (32'(WIDTH) - amt_mod_s) % 32'(WIDTH);
        end else begin
            amt_left_s = amt_mod_s;
        end
`endif
        amt_eff_s = AMT_W'(amt_left_s);
    end

    rotate_left_stages #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_stages (
        .a   (a),
        .amt (amt_eff_s),
        .y   (rot_s)
    );

    // Result holds across idle cycles; valid is a single-cycle strobe.
    always_comb begin
        out_valid_d = in_valid;
        if (in_valid) begin
            y_d = rot_s;
        end else begin
            y_d = y_q;
        end
    end

    // Output stage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rotate_left_unit.sv
// Randomised and directed self-checking bench for rotate_left_unit (8-bit default).
module tb_rotate_left_unit;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  a;
    logic [AW-1:0] amt;
    logic          dir;
    logic [W-1:0]  y;
    logic          out_valid;

    int n_checks;
    int n_fail;
    logic [W-1:0] exp_y;
    logic         exp_v;

    rotate_left_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .amt       (amt),
`ifdef ROTATE_LEFT_BIDIR_EN
        .dir       (dir),
`endif
        .y         (y),
        .out_valid (out_valid)
    );

    rotate_left_unit_chk #(.WIDTH(W), .AMT_W(AW)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .amt       (amt),
`ifdef ROTATE_LEFT_BIDIR_EN
        .dir       (dir),
`endif
        .y         (y),
        .out_valid (out_valid)
    );

    // Clock starts late so the reset value can be observed with no edge at all.
    initial begin
        clk = 1'b0;
        #20;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, want);
        end
    endtask

    // Rotation as multiply/divide by powers of two; right = left by 8 - n.
    function automatic logic [W-1:0] ref_rot(input logic [W-1:0] x, input int n, input bit right);
        int unsigned s;
        int unsigned v;
        s = right ? (W - (n % W)) % W : n % W;
        v = x;
        return W'(((v * (32'd1 << s)) + (v / (32'd1 << (W - s)))) % 256);
    endfunction

    function automatic int popcnt(input logic [W-1:0] x);
        int c;
        c = 0;
        for (int i = 0; i < W; i++) c += int'(x[i]);
        return c;
    endfunction

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input bit v, input logic [W-1:0] aa, input int n, input bit d, input bit chk);
        @(negedge clk);
        in_valid = v;
        a        = aa;
        amt      = AW'(n);
        dir      = d;
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) exp_y = ref_rot(aa, n, d);
        if (chk) begin
            check("out_valid", 32'(out_valid), 32'(exp_v));
            check("y", 32'(y), 32'(exp_y));
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        int rn;
        bit rd;
        bit rv;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        amt      = 3'd0;
        dir      = 1'b0;
        exp_y    = 8'h00;
        exp_v    = 1'b0;

        #1;
        check("reset_y_noclk", 32'(y), 32'h0);
        check("reset_v_noclk", 32'(out_valid), 32'h0);
        in_valid = 1'b1;
        a        = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_y_held", 32'(y), 32'h0);
        check("reset_v_held", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        step(1'b0, 8'h00, 0, 1'b0, 1'b1);

        step(1'b1, 8'b1001_0011, 1, 1'b0, 1'b0);
        check("amt1", 32'(y), 32'h27);
        step(1'b1, 8'b1001_0011, 3, 1'b0, 1'b0);
        check("amt3", 32'(y), 32'h9C);
        step(1'b1, 8'b1001_0011, 5, 1'b0, 1'b0);
        check("amt5", 32'(y), 32'h72);
        step(1'b1, 8'h93, 0, 1'b0, 1'b0);
        check("amt0", 32'(y), 32'h93);
        step(1'b1, 8'h80, 1, 1'b0, 1'b0);
        check("msb_wrap", 32'(y), 32'h01);

        step(1'b1, 8'h5A, 2, 1'b0, 1'b0);
        check("gap_v1", 32'(out_valid), 32'h1);
        step(1'b0, 8'hFF, 7, 1'b0, 1'b0);
        check("gap_v0", 32'(out_valid), 32'h0);
        check("gap_hold", 32'(y), 32'h69);
        step(1'b1, 8'h01, 4, 1'b0, 1'b0);
        check("gap_v2", 32'(out_valid), 32'h1);
        check("gap_y2", 32'(y), 32'h10);

`ifdef ROTATE_LEFT_BIDIR_EN
        step(1'b1, 8'h93, 1, 1'b1, 1'b0);
        check("right1", 32'(y), 32'hC9);
        step(1'b1, 8'h93, 3, 1'b1, 1'b0);
        check("right3", 32'(y), 32'h72);
        step(1'b1, 8'h93, 3, 1'b0, 1'b0);
        check("dir0_left3", 32'(y), 32'h9C);
`endif

        for (int ai = 0; ai < 256; ai++) begin
            for (int ni = 0; ni < W; ni++) begin
                step(1'b1, W'(ai), ni, 1'b0, 1'b1);
            end
        end

        for (int i = 0; i < 400; i++) begin
            ra = W'($urandom);
            rn = int'($urandom_range(0, W - 1));
            rv = ($urandom_range(0, 3) != 0);
`ifdef ROTATE_LEFT_BIDIR_EN
            rd = $urandom_range(0, 1) == 1;
`else
            rd = 1'b0;
`endif
            step(rv, ra, rn, rd, 1'b1);
            if (rv) check("popcount", 32'(popcnt(y)), 32'(popcnt(ra)));
        end

        step(1'b1, 8'hC3, 2, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h3C;
        rst_n    = 1'b0;
        #1;
        check("midrst_v", 32'(out_valid), 32'h0);
        check("midrst_y", 32'(y), 32'h0);
        @(posedge clk);
        #1;
        check("midrst_v_edge", 32'(out_valid), 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_y    = 8'h00;
        step(1'b1, 8'h81, 1, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
